// File: rtl/tick_gen_multi.sv
// Programmable clock divider producing a square slow_clk and a one-cycle tick,
// with up/down speed select, pause, single step and clear.
module tick_gen_multi #(
   parameter int unsigned BASE_HALF  = 500000,
   parameter int unsigned NUM_SPEEDS = 4,
   parameter int unsigned CNT_W      = 32,
   parameter bit          WRAP       = 1'b1,
   parameter int unsigned IDX_W      = $clog2(NUM_SPEEDS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             speed_up_i,
   input  logic             speed_dn_i,
   input  logic             pause_i,
   input  logic             step_i,
   input  logic             clear_i,
   output logic             slow_clk,
   output logic             tick,
   output logic             clear_o,
   output logic             paused_o,
   output logic [IDX_W-1:0] speed_idx_o
);

   localparam int CMD_UP    = 0;
   localparam int CMD_DN    = 1;
   localparam int CMD_PAUSE = 2;
   localparam int CMD_STEP  = 3;
   localparam int CMD_CLEAR = 4;
   localparam int NUM_CMD   = 5;

   localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_SPEEDS - 1);

   logic [NUM_CMD-1:0] cmd;
   logic [NUM_CMD-1:0] cmd_rise;

   assign cmd = {clear_i, step_i, pause_i, speed_dn_i, speed_up_i};

   // History resets to 1 so a level already high at reset release is not an edge.
   generate
      for (genvar gi = 0; gi < NUM_CMD; gi++) begin : g_edge
         logic hist_reg;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) hist_reg <= 1'b1;
            else          hist_reg <= cmd[gi];
         end
         assign cmd_rise[gi] = cmd[gi] & ~hist_reg;
      end
   endgenerate

   logic [CNT_W-1:0] counter_reg, counter_next;
   logic             slow_reg, slow_next;
   logic             tick_reg, tick_next;
   logic             clear_reg, clear_next;
   logic             paused_reg, paused_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic [CNT_W-1:0] limit;
   logic [CNT_W-1:0] limit_m1;
   logic             toggle;

   assign limit    = CNT_W'(BASE_HALF) >> idx_reg;
   assign limit_m1 = limit - CNT_W'(1);

   always_comb begin
      counter_next = counter_reg;
      slow_next    = slow_reg;
      tick_next    = 1'b0;
      clear_next   = 1'b0;
      idx_next     = idx_reg;
      toggle       = 1'b0;
      // The post-toggle pause state governs everything else in this cycle.
      paused_next  = paused_reg ^ cmd_rise[CMD_PAUSE];

      if (cmd_rise[CMD_CLEAR]) begin
         counter_next = '0;
         slow_next    = 1'b0;
         idx_next     = '0;
         clear_next   = 1'b1;
      end else begin
         if (!paused_next) begin
            if (counter_reg >= limit_m1) begin
               counter_next = '0;
               toggle       = 1'b1;
            end else begin
               counter_next = counter_reg + CNT_W'(1);
            end
         end else if (paused_reg && cmd_rise[CMD_STEP] && !cmd_rise[CMD_PAUSE]) begin
            counter_next = '0;
            toggle       = 1'b1;
         end

         if (toggle) begin
            slow_next = ~slow_reg;
            tick_next = ~slow_reg;
         end

         if (!paused_next && cmd_rise[CMD_UP] && !cmd_rise[CMD_DN]) begin
            if (idx_reg == MAX_IDX) idx_next = WRAP ? '0 : MAX_IDX;
            else                    idx_next = idx_reg + IDX_W'(1);
         end else if (!paused_next && cmd_rise[CMD_DN] && !cmd_rise[CMD_UP]) begin
            if (idx_reg == '0) idx_next = WRAP ? MAX_IDX : '0;
            else               idx_next = idx_reg - IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter_reg <= '0;
         slow_reg    <= 1'b0;
         tick_reg    <= 1'b0;
         clear_reg   <= 1'b0;
         paused_reg  <= 1'b0;
         idx_reg     <= '0;
      end else begin
         counter_reg <= counter_next;
         slow_reg    <= slow_next;
         tick_reg    <= tick_next;
         clear_reg   <= clear_next;
         paused_reg  <= paused_next;
         idx_reg     <= idx_next;
      end
   end

   assign slow_clk    = slow_reg;
   assign tick        = tick_reg;
   assign clear_o     = clear_reg;
   assign paused_o    = paused_reg;
   assign speed_idx_o = idx_reg;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: hand-derived vector table, reset
// sequence and randomized commands against a behavioural model.
module tb_tick_gen_multi;

   localparam int BASE_HALF  = 8;
   localparam int NUM_SPEEDS = 4;
   localparam int CNT_W      = 8;
   localparam bit WRAP       = 1'b1;
   localparam int IDX_W      = 2;
   localparam int NUM_VEC    = 45;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic speed_up_i = 1'b0, speed_dn_i = 1'b0, pause_i = 1'b0, step_i = 1'b0, clear_i = 1'b0;
   logic slow_clk, tick, clear_o, paused_o;
   logic [IDX_W-1:0] speed_idx_o;

   tick_gen_multi #(
      .BASE_HALF(BASE_HALF), .NUM_SPEEDS(NUM_SPEEDS), .CNT_W(CNT_W),
      .WRAP(WRAP), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .speed_up_i(speed_up_i), .speed_dn_i(speed_dn_i), .pause_i(pause_i),
      .step_i(step_i), .clear_i(clear_i),
      .slow_clk(slow_clk), .tick(tick), .clear_o(clear_o),
      .paused_o(paused_o), .speed_idx_o(speed_idx_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural reference state, input bit order {clear, step, pause, dn, up}.
   int m_cnt, m_slow, m_tick, m_clr, m_paused, m_idx;
   logic [4:0] m_hist;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_slow = 0; m_tick = 0; m_clr = 0; m_paused = 0; m_idx = 0;
      m_hist = 5'b11111;
   endtask

   task automatic model_clock(input logic [4:0] in);
      logic [4:0] e;
      int lim;
      int run;
      bit flip;
      e = in & ~m_hist;
      m_hist = in;
      run = (m_paused ^ int'(e[2])) == 0;
      m_tick = 0;
      m_clr = 0;
      flip = 0;
      if (e[4]) begin
         m_cnt = 0; m_slow = 0; m_idx = 0; m_clr = 1;
      end else begin
         lim = BASE_HALF / (1 << m_idx);
         if (run != 0) begin
            m_cnt = m_cnt + 1;
            if (m_cnt >= lim) begin m_cnt = 0; flip = 1; end
         end else if (m_paused == 1 && e[3] && !e[2]) begin
            m_cnt = 0; flip = 1;
         end
         if (flip) begin
            m_slow = 1 - m_slow;
            m_tick = m_slow;
         end
         if (run != 0 && e[0] && !e[1])
            m_idx = WRAP ? (m_idx + 1) % NUM_SPEEDS
                         : ((m_idx + 1 > NUM_SPEEDS - 1) ? NUM_SPEEDS - 1 : m_idx + 1);
         else if (run != 0 && e[1] && !e[0])
            m_idx = WRAP ? (m_idx + NUM_SPEEDS - 1) % NUM_SPEEDS
                         : ((m_idx == 0) ? 0 : m_idx - 1);
      end
      m_paused = (run != 0) ? 0 : 1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_slow_clk"}, int'(slow_clk), m_slow);
      chk({tag, "_tick"}, int'(tick), m_tick);
      chk({tag, "_clear_o"}, int'(clear_o), m_clr);
      chk({tag, "_paused_o"}, int'(paused_o), m_paused);
      chk({tag, "_speed_idx"}, int'(speed_idx_o), m_idx);
   endtask

   task automatic cycle(input logic [4:0] in);
      {clear_i, step_i, pause_i, speed_dn_i, speed_up_i} = in;
      @(posedge clk);
      model_clock(in);
      #1;
      check_model("cyc");
   endtask

   // Reset asserted between clock edges; outputs must clear with no clock.
   task automatic async_reset(input logic [4:0] held);
      #3;
      {clear_i, step_i, pause_i, speed_dn_i, speed_up_i} = held;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_slow_clk", int'(slow_clk), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_clear_o", int'(clear_o), 0);
      chk("rst_paused_o", int'(paused_o), 0);
      chk("rst_speed_idx", int'(speed_idx_o), 0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic [4:0] in;
      int n;
      int slow, tck, clr, pau, idx;
   } vec_t;

   vec_t tbl [NUM_VEC];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0] r_in;

      tbl = '{
         '{5'b00000,   8, 1,1,0,0,0}, '{5'b00000,   1, 1,0,0,0,0}, '{5'b00000,   7, 0,0,0,0,0},
         '{5'b00001,   1, 0,0,0,0,1}, '{5'b00000,   1, 0,0,0,0,1}, '{5'b00001,   1, 0,0,0,0,2},
         '{5'b00000,   1, 1,1,0,0,2}, '{5'b00001,   1, 1,0,0,0,3}, '{5'b00000,   1, 0,0,0,0,3},
         '{5'b00000,   1, 1,1,0,0,3}, '{5'b00000,   1, 0,0,0,0,3}, '{5'b00000,   1, 1,1,0,0,3},
         '{5'b00001,   1, 0,0,0,0,0}, '{5'b00000,   1, 0,0,0,0,0}, '{5'b00010,   1, 0,0,0,0,3},
         '{5'b00000,   1, 1,1,0,0,3}, '{5'b00001,   1, 0,0,0,0,0}, '{5'b00000,   1, 0,0,0,0,0},
         '{5'b00000,   4, 0,0,0,0,0}, '{5'b00100,   1, 0,0,0,1,0}, '{5'b00001,   1, 0,0,0,1,0},
         '{5'b00000, 100, 0,0,0,1,0}, '{5'b01000,   1, 1,1,0,1,0}, '{5'b00000,   1, 1,0,0,1,0},
         '{5'b01000,   1, 0,0,0,1,0}, '{5'b00000,   3, 0,0,0,1,0}, '{5'b00100,   1, 0,0,0,0,0},
         '{5'b00000,   6, 0,0,0,0,0}, '{5'b00000,   1, 1,1,0,0,0}, '{5'b00000,   6, 1,0,0,0,0},
         '{5'b00001,   1, 1,0,0,0,1}, '{5'b00000,   1, 0,0,0,0,1}, '{5'b00000,   3, 0,0,0,0,1},
         '{5'b00000,   1, 1,1,0,0,1}, '{5'b00001,   1, 1,0,0,0,2}, '{5'b00100,   1, 1,0,0,1,2},
         '{5'b10000,   1, 0,0,1,1,0}, '{5'b00000,   1, 0,0,0,1,0}, '{5'b00100,   1, 0,0,0,0,0},
         '{5'b00011,   1, 0,0,0,0,0}, '{5'b00000,   1, 0,0,0,0,0}, '{5'b10100,   1, 0,0,1,1,0},
         '{5'b00000,   1, 0,0,0,1,0}, '{5'b00100,   1, 0,0,0,0,0}, '{5'b00000,   1, 0,0,0,0,0}
      };

      // Reset from power-up with all commands low.
      #2;
      reset_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_model("reset");
      reset_n = 1'b1;

      for (int v = 0; v < NUM_VEC; v++) begin
         for (int k = 0; k < tbl[v].n; k++) cycle(tbl[v].in);
         chk($sformatf("vec%0d_slow_clk", v), int'(slow_clk), tbl[v].slow);
         chk($sformatf("vec%0d_tick", v), int'(tick), tbl[v].tck);
         chk($sformatf("vec%0d_clear_o", v), int'(clear_o), tbl[v].clr);
         chk($sformatf("vec%0d_paused_o", v), int'(paused_o), tbl[v].pau);
         chk($sformatf("vec%0d_speed_idx", v), int'(speed_idx_o), tbl[v].idx);
         $display("vec %0d: in=%b x%0d -> slow=%0d tick=%0d clr=%0d paused=%0d idx=%0d",
                  v, tbl[v].in, tbl[v].n, slow_clk, tick, clear_o, paused_o, speed_idx_o);
      end

      // Mid-period reset with speed_up held high through release.
      cycle(5'b00000);
      cycle(5'b00000);
      async_reset(5'b00001);
      for (int k = 0; k < 3; k++) cycle(5'b00001);
      chk("held_up_idx", int'(speed_idx_o), 0);
      chk("held_up_slow", int'(slow_clk), 0);
      $display("reset seq: up held through release -> idx=%0d", speed_idx_o);
      cycle(5'b00000);
      cycle(5'b00001);
      chk("reup_idx", int'(speed_idx_o), 1);
      $display("reset seq: up re-pressed -> idx=%0d", speed_idx_o);

      // Randomized command traffic against the model.
      r_in = 5'b00000;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) r_in[b] = ~r_in[b];
         if ($urandom_range(0, 39) == 0) r_in[4] = ~r_in[4];
         if (c == 1500) async_reset(r_in);
         cycle(r_in);
      end
      $display("random: 3000 cycles applied");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
